multi_iter: RTL and testbench

Parametrised iterative shift-add multiplier; successor to the fixed 8-bit multiplier.
- Buffers operand pairs in a small input FIFO under valid/ready handshake.
- Computes signed or unsigned products one set multiplier bit per cycle, terminating early when the multiplier is exhausted.
- Holds each result under output backpressure.
- Sits between the operand scheduler and the accumulation/writeback stage of the compute array.

---
 rtl/multi_pkg.sv | 45 ++++
 rtl/multi_op_fifo.sv | 47 ++++
 rtl/multi_iter.sv | 147 ++++++++++++++
 tb/tb_multi_iter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package multi_pkg;

    // Operand fields are sized for the widest legal DATA_W. Narrower builds
    // leave the upper bits at zero and synthesis removes them.
    localparam int OP_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_MAX_W-1:0] data0;
        logic [OP_MAX_W-1:0] data1;
        logic                is_signed;
    } op_pair_t;

    // Index of the highest set bit; 0 when v is zero.
    function automatic logic [4:0] hsb_idx(input logic [OP_MAX_W-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < OP_MAX_W; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    // Magnitude of the w-bit value in v. The most-negative signed value maps
    // to 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [OP_MAX_W-1:0] mag(input logic [OP_MAX_W-1:0] v,
                                                input int                  w,
                                                input logic                sgn);
        logic [OP_MAX_W-1:0] mask;
        logic [OP_MAX_W-1:0] r;
        mask = {OP_MAX_W{1'b1}} >> (OP_MAX_W - w);
        r    = v & mask;
        if (sgn && r[w-1]) r = (~r + 1'b1) & mask;
        return r;
    endfunction

endpackage

// File: rtl/multi_op_fifo.sv
// Synchronous operand-pair FIFO, DEPTH entries of WIDTH bits, head is combinational.
// Latency: an entry pushed at edge T is visible on head after T.
// Backpressure: push is ignored while full, pop is ignored while empty.
// Ports: clk/rst (async active-high), push/push_data, pop, full, empty, head.
module multi_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/multi_iter.sv
// Iterative signed/unsigned shift-add multiplier, one set multiplier bit per cycle.
// Latency: push at T -> pop at T+1 -> out_vld after T+1+max(1,popcount(|in1|)).
// Backpressure: in_rdy = ~fifo_full; results held stable in DONE until out_rdy.
// Ports: clk, rst (async active-high); in_vld/in_rdy/in0_data/in1_data/in_signed
//        operand push; out_vld/out_rdy/out_data result; busy = work pending.
// Optional MULTI_ACC_EN: adds acc_clr and a running sum; out_data = sum + product.
module multi_iter
    import multi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [DATA_W-1:0]   in0_data,
    input  logic [DATA_W-1:0]   in1_data,
    input  logic                in_signed,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [2*DATA_W-1:0] out_data,
    output logic                busy
`ifdef MULTI_ACC_EN
    ,
    input  logic                acc_clr
`endif
);
    localparam int PW = 2 * DATA_W;

    op_pair_t            push_pair;
    op_pair_t            head_pair;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                out_hs;

    state_t              state;
    state_t              state_nxt;

    logic [PW-1:0]       mcand;
    logic [PW-1:0]       acc;
    logic [PW-1:0]       acc_nxt;
    logic [PW-1:0]       prod;
    logic [PW-1:0]       result;
    logic [DATA_W-1:0]   mplr;
    logic [DATA_W-1:0]   mplr_nxt;
    logic                neg;
    logic [4:0]          hsb;
    logic                calc_last;
    logic [OP_MAX_W-1:0] mag0;
    logic [OP_MAX_W-1:0] mag1;

    always_comb begin
        push_pair           = '0;
        push_pair.data0     = OP_MAX_W'(in0_data);
        push_pair.data1     = OP_MAX_W'(in1_data);
        push_pair.is_signed = in_signed;
    end

    multi_op_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(op_pair_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_vld & in_rdy),
        .push_data (push_pair),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_pair)
    );

    assign in_rdy  = ~fifo_full;
    assign out_vld = (state == DONE);
    assign out_hs  = (state == DONE) && out_rdy;
    assign busy    = !fifo_empty || (state != IDLE);
    // Popping straight out of DONE removes the IDLE bubble between results.
    assign pop     = !fifo_empty && ((state == IDLE) || out_hs);

    assign mag0 = mag(head_pair.data0, DATA_W, head_pair.is_signed);
    assign mag1 = mag(head_pair.data1, DATA_W, head_pair.is_signed);

    // One CALC step: retire the highest remaining multiplier bit. A zero
    // multiplier leaves acc untouched and still finishes in one cycle.
    always_comb begin
        hsb     = hsb_idx(OP_MAX_W'(mplr));
        acc_nxt = acc;
        if (mplr != '0) acc_nxt = acc + (mcand << hsb);
        mplr_nxt  = mplr & ~(DATA_W'(1) << hsb);
        calc_last = (mplr_nxt == '0);
        prod      = neg ? (PW'(0) - acc_nxt) : acc_nxt;
    end

`ifdef MULTI_ACC_EN
    logic [PW-1:0] sum;
    assign result = sum + prod;

    // out_data already holds sum + product while in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (out_hs) begin
            sum <= acc_clr ? '0 : out_data;
        end
    end
`else
    assign result = prod;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = CALC;
            CALC:    if (calc_last)   state_nxt = DONE;
            DONE:    if (out_rdy)     state_nxt = fifo_empty ? IDLE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            mplr     <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            out_data <= '0;
        end else if (pop) begin
            mcand <= PW'(DATA_W'(mag0));
            mplr  <= DATA_W'(mag1);
            neg   <= head_pair.is_signed &
                     (head_pair.data0[DATA_W-1] ^ head_pair.data1[DATA_W-1]);
            acc   <= '0;
        end else if (state == CALC) begin
            acc  <= acc_nxt;
            mplr <= mplr_nxt;
            if (calc_last) out_data <= result;
        end
    end

endmodule

// File: tb/tb_multi_iter.sv
// Scoreboard bench for multi_iter: driver queues expected products, monitor checks results.
// Latency: checks pop-to-result timing against popcount of the multiplier magnitude.
// Backpressure: exercises held results, FIFO full, and random out_rdy.
module tb_multi_iter;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 2 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] in0_data;
    logic [DW-1:0] in1_data;
    logic          in_signed;
    logic          out_vld;
    logic          out_rdy;
    logic [PW-1:0] out_data;
    logic          busy;
    logic          out_rdy_man;
    logic          rnd_bp;
    logic          rnd_bit;
`ifdef MULTI_ACC_EN
    logic          acc_clr;
`endif

    assign out_rdy = rnd_bp ? rnd_bit : out_rdy_man;

    typedef struct {
        logic [PW-1:0] prod;
        logic          clr;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [PW-1:0] mon_want;
    logic [PW-1:0] model_sum;
    logic [PW-1:0] last_out;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_hs  = 0;

    multi_iter #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in0_data  (in0_data),
        .in1_data  (in1_data),
        .in_signed (in_signed),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .busy      (busy)
`ifdef MULTI_ACC_EN
        ,
        .acc_clr   (acc_clr)
`endif
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: operand value as an integer, exact product, truncated.
    function automatic longint sval(input logic [DW-1:0] v, input logic s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    function automatic logic [PW-1:0] ref_prod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic s);
        longint p;
        p = sval(a, s) * sval(b, s);
        return p[PW-1:0];
    endfunction

    function automatic int calc_len(input logic [DW-1:0] b, input logic s);
        longint m;
        int     c;
        m = sval(b, s);
        if (m < 0) m = -m;
        c = $countones(m);
        return (c == 0) ? 1 : c;
    endfunction

    // Monitor: every result handshake is checked against the queue head.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got 0x%0h, expected no result", out_data);
            end else begin
                mon_e = exp_q.pop_front();
`ifdef MULTI_ACC_EN
                mon_want  = model_sum + mon_e.prod;
                acc_clr   = mon_e.clr;
                model_sum = mon_e.clr ? '0 : mon_want;
`else
                mon_want  = mon_e.prod;
`endif
                check("out_data", 64'(out_data), 64'(mon_want));
                last_out = out_data;
            end
        end
    end

    // Drives a pair and returns #1 after the edge that accepted it (in_vld left high).
    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                        input logic clr);
        int   t;
        exp_t e;
        t         = 0;
        in_vld    = 1'b1;
        in0_data  = a;
        in1_data  = b;
        in_signed = s;
        while (!in_rdy && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: in_rdy stayed 0, expected 1");
        end else begin
            @(posedge clk);
            e.prod = ref_prod(a, b, s);
            e.clr  = clr;
            exp_q.push_back(e);
            #1;
        end
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (!out_vld && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    // Single pair into an idle DUT with out_rdy=1; checks latency and value.
    task automatic run_one(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                           input logic clr, input logic [PW-1:0] lit, input string name);
        int cnt;
        out_rdy_man = 1'b1;
        push(a, b, s, clr);
        in_vld = 1'b0;
        wait_out(cnt);
        check({name, "_latency"}, 64'(cnt), 64'(1 + calc_len(b, s)));
        @(posedge clk);
        #1;
        check({name, "_value"}, 64'(last_out), 64'(lit));
    endtask

    logic [DW-1:0] bp_a [5];
    logic [DW-1:0] bp_b [5];
    logic          bp_s [5];

    initial begin
        int            cnt;
        int            want;
        int            hs0;
        logic [PW-1:0] held;

        rst         = 1'b1;
        in_vld      = 1'b0;
        in0_data    = '0;
        in1_data    = '0;
        in_signed   = 1'b0;
        out_rdy_man = 1'b0;
        rnd_bp      = 1'b0;
        model_sum   = '0;
        last_out    = '0;
`ifdef MULTI_ACC_EN
        acc_clr     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_rdy",   64'(in_rdy),   64'(1));
        check("rst_out_vld",  64'(out_vld),  64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_busy",     64'(busy),     64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef MULTI_ACC_EN
        run_one(8'd2, 8'd3, 1'b0, 1'b0, 16'd6,  "acc_2x3");
        run_one(8'd4, 8'd5, 1'b0, 1'b0, 16'd26, "acc_4x5");
        run_one(8'd1, 8'd1, 1'b0, 1'b1, 16'd27, "acc_1x1_clr");
        run_one(8'd2, 8'd2, 1'b0, 1'b1, 16'd4,  "acc_2x2");
`endif

        run_one(8'd3, 8'd5, 1'b0, 1'b1, 16'd15, "u_3x5");
        check("busy_after_u_3x5", 64'(busy), 64'(0));
        run_one(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, "s_min_sq");
        run_one(8'hF9, 8'd6,  1'b1, 1'b1, 16'hFFD6, "s_m7x6");
        run_one(8'h7F, 8'hFF, 1'b1, 1'b1, 16'hFF81, "s_127xm1");
        run_one(8'hAB, 8'h00, 1'b0, 1'b1, 16'h0000, "zero_mplr");
        run_one(8'h00, 8'hFF, 1'b0, 1'b1, 16'h0000, "zero_mcand");

        // Backpressure: five pairs, the first is held in DONE while four fill the FIFO.
        out_rdy_man = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = DW'($urandom);
            bp_b[i] = DW'($urandom);
            bp_s[i] = 1'($urandom_range(0, 1));
            push(bp_a[i], bp_b[i], bp_s[i], 1'b1);
        end
        in_vld = 1'b0;
        check("full_in_rdy", 64'(in_rdy), 64'(0));
        wait_out(cnt);
        check("bp_first_vld", 64'(out_vld), 64'(1));
        held = out_data;
        check("bp_first_value", 64'(held), 64'(ref_prod(bp_a[0], bp_b[0], bp_s[0])));
        repeat (5) @(posedge clk);
        #1;
        check("bp_hold_vld",  64'(out_vld),  64'(1));
        check("bp_hold_data", 64'(out_data), 64'(held));
        check("bp_hold_full", 64'(in_rdy),   64'(0));
        // Back-to-back drain: one handshake edge, then CALC length + 1 per result.
        want = 1;
        for (int i = 1; i < 5; i++) want += calc_len(bp_b[i], bp_s[i]) + 1;
        hs0         = n_hs;
        out_rdy_man = 1'b1;
        cnt         = 0;
        while ((n_hs - hs0) < 5 && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("bp_drain_cycles", 64'(cnt), 64'(want));

        // Random traffic with random downstream stalls.
        rnd_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            in_vld = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        cnt = 0;
        while ((exp_q.size() != 0 || busy) && cnt < 3000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("rand_drained", 64'(exp_q.size()), 64'(0));
        rnd_bp      = 1'b0;
        out_rdy_man = 1'b1;

        // Reset in the middle of a long computation.
        push(8'hFF, 8'hFF, 1'b0, 1'b1);
        in_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midcalc_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        exp_q.delete();
        model_sum = '0;
        #1;
        check("midrst_out_vld", 64'(out_vld), 64'(0));
        check("midrst_in_rdy",  64'(in_rdy),  64'(1));
        check("midrst_busy",    64'(busy),    64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_one(8'd2, 8'd2, 1'b0, 1'b1, 16'd4, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
